// File: rtl/word_collector_if.sv
// Byte-in / word-out handshake bundle for word_collector.
// The DUT side uses the slave modport; a byte source / word sink uses master.
interface word_collector_if #(
  parameter int WIDTH = 32
);
  localparam int DATA_WIDTH = 8;
  localparam int WIDTH_BITS = $clog2(WIDTH) + 1;

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_word [WIDTH];
  logic [WIDTH_BITS-1:0] o_len;
  logic                  o_valid;
  logic                  o_eol;
  logic                  i_ack;
  logic                  o_err;

  modport slave (
    input  i_data, i_valid, i_ack,
    output o_ready, o_word, o_len, o_valid, o_eol, o_err
  );

  modport master (
    output i_data, i_valid, i_ack,
    input  o_ready, o_word, o_len, o_valid, o_eol, o_err
  );
endinterface

// File: rtl/word_collector.sv
// Forth lexer front end: splits a UART byte stream into whitespace-delimited words.
// Optional macro WORD_COLLECTOR_UPCASE_EN folds 'a'..'z' to upper case on store.
module word_collector #(
  parameter int WIDTH = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  word_collector_if.slave bus
);
  localparam int DATA_WIDTH = 8;
  localparam int WIDTH_BITS = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q [WIDTH];
  logic [DATA_WIDTH-1:0] word_d [WIDTH];
  logic [WIDTH_BITS-1:0] len_q, len_d;
  logic                  eol_q, eol_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  is_delim;
  logic                  is_newline;
  logic [DATA_WIDTH-1:0] char_in;

  assign accept     = bus.i_valid && (state_q != DONE);
  assign is_newline = (bus.i_data == 8'h0D) || (bus.i_data == 8'h0A);
  assign is_delim   = is_newline || (bus.i_data == 8'h20) || (bus.i_data == 8'h09);

`ifdef WORD_COLLECTOR_UPCASE_EN
  assign char_in = ((bus.i_data >= 8'h61) && (bus.i_data <= 8'h7A)) ?
                   (bus.i_data - 8'h20) : bus.i_data;
`else
  assign char_in = bus.i_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      for (int i = 0; i < WIDTH; i++) begin
        word_q[i] <= '0;
      end
      len_q <= '0;
      eol_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    eol_d   = eol_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && !is_delim) begin
          for (int i = 0; i < WIDTH; i++) begin
            word_d[i] = '0;
          end
          word_d[0] = char_in;
          len_d     = WIDTH_BITS'(1);
          state_d   = COLLECT;
        end
      end

      COLLECT: begin
        if (accept) begin
          if (is_delim) begin
            eol_d   = is_newline;
            state_d = DONE;
          end else if (len_q < WIDTH_BITS'(WIDTH)) begin
            // len_q is the index of the next free slot
            for (int i = 0; i < WIDTH; i++) begin
              if (len_q == WIDTH_BITS'(i)) begin
                word_d[i] = char_in;
              end
            end
            len_d = len_q + WIDTH_BITS'(1);
          end else begin
            err_d   = 1'b1;
            len_d   = '0;
            state_d = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (accept && is_delim) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        if (bus.i_ack) begin
          eol_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready = (state_q != DONE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_word  = word_q;
  assign bus.o_len   = len_q;
  assign bus.o_eol   = eol_q;
  assign bus.o_err   = err_q;
endmodule

// File: tb/tb_word_collector.sv
// Directed bench for word_collector with hand-computed expected words.
module tb_word_collector;
  logic clk;
  logic rst;

  int compare_cnt = 0;
  int mismatch_cnt = 0;
  int valid_rises = 0;
  int err_cycles = 0;
  logic prev_valid = 1'b0;
  int valid_snap;
  int err_snap;

  word_collector_if #(.WIDTH(32)) bus ();

  word_collector #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count o_valid rising edges and o_err high cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.o_valid && !prev_valid) valid_rises = valid_rises + 1;
    if (bus.o_err) err_cycles = err_cycles + 1;
    prev_valid = bus.o_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_cnt++;
    if (actual !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and return #1 after the edge on which it transferred
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.i_data  = b;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.o_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_data  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_ack   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_ready", bus.o_ready, 1);
    checkOutput("rst_valid", bus.o_valid, 0);
    checkOutput("rst_len", bus.o_len, 0);
    checkOutput("rst_word0", bus.o_word[0], 0);
    checkOutput("rst_err", bus.o_err, 0);
    checkOutput("rst_eol", bus.o_eol, 0);

    // "  42 " with ack held high
    bus.i_ack = 1'b1;
    valid_snap = valid_rises;
    send_string("  42");
    checkOutput("t1_valid_before_delim", bus.o_valid, 0);
    applyStimulus(8'h20);
    checkOutput("t1_valid_latency", bus.o_valid, 1);
    checkOutput("t1_word0", bus.o_word[0], 8'h34);
    checkOutput("t1_word1", bus.o_word[1], 8'h32);
    checkOutput("t1_len", bus.o_len, 2);
    checkOutput("t1_eol", bus.o_eol, 0);
    tick();
    tick();
    checkOutput("t1_valid_pulses", valid_rises - valid_snap, 1);
    checkOutput("t1_valid_after_ack", bus.o_valid, 0);

    // "DUP\n" stalled for 5 cycles while 'X' waits on the input
    bus.i_ack = 1'b0;
    send_string("DUP\n");
    bus.i_data  = "X";
    bus.i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("t2_valid_hold", bus.o_valid, 1);
      checkOutput("t2_ready_low", bus.o_ready, 0);
      checkOutput("t2_len", bus.o_len, 3);
      checkOutput("t2_eol", bus.o_eol, 1);
      checkOutput("t2_word0", bus.o_word[0], "D");
      checkOutput("t2_word1", bus.o_word[1], "U");
      checkOutput("t2_word2", bus.o_word[2], "P");
    end
    tick();
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    checkOutput("t2_valid_after_ack", bus.o_valid, 0);
    checkOutput("t2_eol_after_ack", bus.o_eol, 0);
    checkOutput("t2_len_held", bus.o_len, 3);
    tick();
    bus.i_valid = 1'b0;
    checkOutput("t2_x_word0", bus.o_word[0], "X");
    checkOutput("t2_x_word1_cleared", bus.o_word[1], 0);
    checkOutput("t2_x_len", bus.o_len, 1);
    bus.i_ack = 1'b1;
    applyStimulus(8'h20);
    checkOutput("t2_x_valid", bus.o_valid, 1);
    tick();

    // Exactly WIDTH characters is a legal word
    bus.i_ack = 1'b0;
    err_snap = err_cycles;
    for (int i = 0; i < 32; i++) applyStimulus("A");
    applyStimulus(8'h20);
    checkOutput("t3_len32", bus.o_len, 32);
    checkOutput("t3_valid", bus.o_valid, 1);
    checkOutput("t3_word31", bus.o_word[31], "A");
    checkOutput("t3_eol", bus.o_eol, 0);
    @(negedge clk);
    checkOutput("t3_no_err", err_cycles - err_snap, 0);
    tick();
    bus.i_ack = 1'b1;
    tick();

    // Overflow on character 33, then " 7 "
    valid_snap = valid_rises;
    err_snap = err_cycles;
    for (int i = 0; i < 32; i++) applyStimulus("A");
    checkOutput("t4_err_before", bus.o_err, 0);
    applyStimulus("A");
    checkOutput("t4_err_pulse", bus.o_err, 1);
    checkOutput("t4_len_zero", bus.o_len, 0);
    tick();
    checkOutput("t4_err_cleared", bus.o_err, 0);
    send_string(" 7");
    checkOutput("t4_no_valid_yet", valid_rises - valid_snap, 0);
    applyStimulus(8'h20);
    checkOutput("t4_valid", bus.o_valid, 1);
    checkOutput("t4_word0", bus.o_word[0], 8'h37);
    checkOutput("t4_len", bus.o_len, 1);
    tick();
    tick();
    checkOutput("t4_valid_pulses", valid_rises - valid_snap, 1);
    checkOutput("t4_err_cycles", err_cycles - err_snap, 1);

    // Reset in the middle of "12"
    bus.i_ack = 1'b0;
    send_string("12");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_ready", bus.o_ready, 1);
    checkOutput("t5_valid", bus.o_valid, 0);
    checkOutput("t5_len", bus.o_len, 0);
    checkOutput("t5_word0", bus.o_word[0], 0);
    checkOutput("t5_word1", bus.o_word[1], 0);
    checkOutput("t5_eol", bus.o_eol, 0);
    checkOutput("t5_err", bus.o_err, 0);
    bus.i_ack = 1'b1;
    send_string(" 5 ");
    checkOutput("t5_valid_5", bus.o_valid, 1);
    checkOutput("t5_word0_5", bus.o_word[0], 8'h35);
    checkOutput("t5_word1_5", bus.o_word[1], 0);
    checkOutput("t5_len_5", bus.o_len, 1);
    tick();

    // Case folding depends on the build
    send_string("dup ");
    checkOutput("t6_len", bus.o_len, 3);
`ifdef WORD_COLLECTOR_UPCASE_EN
    checkOutput("t6_word0", bus.o_word[0], 8'h44);
    checkOutput("t6_word1", bus.o_word[1], 8'h55);
    checkOutput("t6_word2", bus.o_word[2], 8'h50);
`else
    checkOutput("t6_word0", bus.o_word[0], 8'h64);
    checkOutput("t6_word1", bus.o_word[1], 8'h75);
    checkOutput("t6_word2", bus.o_word[2], 8'h70);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end
endmodule

// File: doc/word_collector.md
Name: word_collector

Overview:
- Front-end lexer stage of the Forth compiler; sits directly upstream of the word-to-integer converter and the dictionary lookup.
- Consumes the UART byte stream one character per handshake and splits it into whitespace-delimited words.
- Presents each complete word as a character array plus length, held stable until the downstream stage acknowledges it.

Parameters:
- WIDTH, 32: maximum word length in characters; sets the output array depth.
- DATA_WIDTH, 8: character width. Localparam, fixed, matches the UART.
- WIDTH_BITS: localparam, $clog2(WIDTH)+1; the width of o_len.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous active-high reset.
- i_data  input  DATA_WIDTH  incoming character from the UART receiver.
- i_valid  input  1  i_data is valid this cycle.
- o_ready  output  1  block accepts i_data this cycle; a byte transfers when i_valid && o_ready.
- o_word  output  DATA_WIDTH x WIDTH  unpacked array; index 0 is the first character.
- o_len  output  WIDTH_BITS  number of valid characters in o_word (1..WIDTH).
- o_valid  output  1  a complete word is presented.
- o_eol  output  1  the presented word was terminated by CR or LF; qualified by o_valid.
- i_ack  input  1  downstream consumes the word; effective only while o_valid=1.
- o_err  output  1  one-cycle pulse: word overflow, word discarded.

Behaviour:
- Reset is synchronous, active-high, and overrides everything including a word in progress. Reset values:
  - o_word all 0, o_len 0, o_valid 0, o_eol 0, o_err 0, o_ready 1.
  - State IDLE.
- Delimiters are space 0x20, tab 0x09, CR 0x0D and LF 0x0A. Every other byte is a word character.
- State IDLE, o_ready=1:
  - Delimiter accepted: dropped, stay in IDLE.
  - Word character accepted: clear all o_word entries, write it to o_word[0], set o_len=1, go to COLLECT.
- State COLLECT, o_ready=1:
  - Word character accepted with o_len<WIDTH: write it to o_word[o_len], increment o_len.
  - Word character accepted with o_len==WIDTH: pulse o_err for exactly 1 cycle, set o_len=0, go to DISCARD.
  - Delimiter accepted: set o_eol=1 if the delimiter is CR/LF, else 0; go to DONE. o_valid rises the cycle after the delimiter handshake, so latency is 1 cycle.
- State DISCARD, o_ready=1:
  - Word characters are dropped.
  - A delimiter returns the block to IDLE. No word is emitted and o_valid stays 0.
- State DONE:
  - o_valid=1, o_ready=0. The UART stalls; no byte is lost.
  - o_word, o_len and o_eol are held stable.
  - i_ack=1 moves to IDLE on the next edge: o_valid=0, o_eol=0, o_ready=1. o_word and o_len keep their last values until the next word starts.
- i_ack in any state other than DONE is ignored.
- o_valid can only be 1 in DONE. A word can never be empty.
- A word of exactly WIDTH characters is legal and is emitted normally. Overflow occurs only on character WIDTH+1.
- o_err is only ever a single-cycle pulse and never coincides with o_valid.
- Back-to-back words with one delimiter between them incur no extra bubbles beyond the DONE/ack cycle.
- When i_valid=0, the state and all outputs hold.

Optional Feature:
- Macro: WORD_COLLECTOR_UPCASE_EN.
- Defined: characters 'a'..'z' (0x61..0x7A) are stored as 0x41..0x5A, giving case-insensitive dictionary matching downstream. All other bytes are stored unchanged.
- Undefined: bytes are stored verbatim.
- Delimiter detection is identical in both builds.

Test Plan:
- Reset, then stream "  42 " with i_ack held 1:
  - o_valid pulses once.
  - o_word[0]=0x34, o_word[1]=0x32, o_len=2, o_eol=0.
  - o_valid rises exactly 1 cycle after the final-space handshake.
- Stream "DUP\n" with i_ack=0 for 5 cycles, then 1:
  - o_valid and o_word ("D","U","P") stable for all 5 cycles, o_len=3, o_eol=1, o_ready=0 throughout.
  - Next bytes are accepted only after the ack.
- Stream 32 'A' then a space (WIDTH=32): o_len=32, o_valid=1, o_err stays 0.
- Stream 33 'A', then " 7 ":
  - o_err pulses 1 cycle on the 33rd character; no word is emitted for the A's.
  - Next emitted word is "7" with o_len=1.
- Assert i_reset mid-word after "12":
  - All outputs return to reset values.
  - A following " 5 " yields o_word[0]=0x35, o_word[1]=0, o_len=1.
- With WORD_COLLECTOR_UPCASE_EN defined, stream "dup ": o_word = 0x44, 0x55, 0x50. Without the macro: 0x64, 0x75, 0x70.
